cdb_rr_arbiter: RTL

- Shares the single common data bus (CDB) among NUM_REQ functional-unit result producers: ALU RS units, load/store unit, branch unit, and similar.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Drives a registered CDB broadcast consumed by reservation stations, the register file and the ROB.
- Honours pipeline flush.

---
 rtl/cdb_rr_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter sharing one registered common data bus among NUM_REQ result producers.
// The grant is combinational from a rotating priority pointer; the broadcast is registered one cycle later.
module cdb_rr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 3,
  localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          cdb_valid,
  output logic [TAG_WIDTH-1:0]          cdb_tag,
  output logic [DATA_WIDTH-1:0]         cdb_data,
  output logic [IdW-1:0]                grant_id
);

  logic [IdW-1:0]        ptr_q, ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [IdW-1:0]        gnt_idx;
  logic                  found;
  logic                  xfer;

  // Priority search starting at ptr_q, wrapping past the highest index.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IdW'(idx);
      end
    end
  end

  assign req_ready = (rst_n && !flush) ? gnt : '0;
  assign xfer      = |req_ready;

  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = xfer;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    grant_id_d  = grant_id_q;
    if (xfer) begin
      cdb_tag_d  = req_tag[gnt_idx*TAG_WIDTH +: TAG_WIDTH];
      cdb_data_d = req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      grant_id_d = gnt_idx;
      ptr_d      = IdW'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      grant_id_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign grant_id  = grant_id_q;

endmodule
